// File: rtl/dmem_mmio_uart.sv
// MMIO UART transmitter on the CPU data bus: DATA push port, STATUS readback, TX FIFO, 8N1 serializer.
// Reads are combinational; pushes into a full FIFO are dropped and flagged in a sticky overflow bit.
module dmem_mmio_uart #(
   parameter int          CLKS_PER_BIT = 16,
   parameter int          FIFO_DEPTH   = 8,
   parameter logic [31:0] BASE_ADDR    = 32'h1000_0000
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] dmem_addr,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_wstrb,
   input  logic        dmem_we,
   output logic [31:0] dmem_rdata,
   output logic        uart_tx,
   output logic        tx_busy
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam int BW = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   logic [7:0]    mem [FIFO_DEPTH];
   logic [AW-1:0] rd_ptr, wr_ptr;
   logic [CW-1:0] count;
   logic          overflow;

   state_t        state, state_nxt;
   logic [BW-1:0] baud, baud_nxt;
   logic [2:0]    bit_idx, bit_idx_nxt;
   logic [7:0]    shift, shift_nxt;

   logic          sel, sel_data, sel_status;
   logic          push_req, push_ok, pop, ovf_set, ovf_clr;
   logic          full, empty, baud_done;
   logic [7:0]    head;
   logic [6:0]    count7;
   logic          unused;

   assign sel        = (dmem_addr[31:3] == BASE_ADDR[31:3]);
   assign sel_data   = sel && !dmem_addr[2];
   assign sel_status = sel && dmem_addr[2];

   assign full  = (count == CW'(FIFO_DEPTH));
   assign empty = (count == '0);
   assign head  = mem[rd_ptr];

   assign push_req = dmem_we && sel_data && dmem_wstrb[0];
   // A pop in the same cycle frees a slot, so a push into a full FIFO still lands.
   assign push_ok  = push_req && (!full || pop);
   assign ovf_set  = push_req && full && !pop;
   assign ovf_clr  = dmem_we && sel_status && dmem_wstrb[0] && dmem_wdata[3];

   always_ff @(posedge clk) begin
      if (rst) begin
         rd_ptr   <= '0;
         wr_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end else begin
         if (push_ok) begin
            mem[wr_ptr] <= dmem_wdata[7:0];
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (pop)
            rd_ptr <= rd_ptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         if (ovf_set)
            overflow <= 1'b1;
         else if (ovf_clr)
            overflow <= 1'b0;
      end
   end

   assign baud_done = (baud == BW'(CLKS_PER_BIT - 1));

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         baud    <= '0;
         bit_idx <= '0;
         shift   <= '0;
      end else begin
         state   <= state_nxt;
         baud    <= baud_nxt;
         bit_idx <= bit_idx_nxt;
         shift   <= shift_nxt;
      end
   end

   always_comb begin
      state_nxt   = state;
      baud_nxt    = baud;
      bit_idx_nxt = bit_idx;
      shift_nxt   = shift;
      pop         = 1'b0;
      case (state)
         IDLE: begin
            if (!empty) begin
               pop       = 1'b1;
               shift_nxt = head;
               baud_nxt  = '0;
               state_nxt = START;
            end
         end
         START: begin
            if (baud_done) begin
               baud_nxt    = '0;
               bit_idx_nxt = '0;
               state_nxt   = DATA;
            end else begin
               baud_nxt = baud + 1'b1;
            end
         end
         DATA: begin
            if (baud_done) begin
               baud_nxt = '0;
               if (bit_idx == 3'd7)
                  state_nxt = STOP;
               else
                  bit_idx_nxt = bit_idx + 1'b1;
            end else begin
               baud_nxt = baud + 1'b1;
            end
         end
         STOP: begin
            if (baud_done) begin
               baud_nxt = '0;
               // Chain straight into the next start bit when more data is queued.
               if (!empty) begin
                  pop       = 1'b1;
                  shift_nxt = head;
                  state_nxt = START;
               end else begin
                  state_nxt = IDLE;
               end
            end else begin
               baud_nxt = baud + 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_comb begin
      uart_tx = 1'b1;
      case (state)
         START:   uart_tx = 1'b0;
         DATA:    uart_tx = shift[bit_idx];
         default: uart_tx = 1'b1;
      endcase
   end

   assign tx_busy = (state != IDLE);
   assign count7  = 7'(count);

   always_comb begin
      dmem_rdata = 32'h0;
      if (sel_status)
         dmem_rdata = {21'h0, count7, overflow, tx_busy, empty, full};
   end

   assign unused = ^{dmem_addr[1:0], dmem_wdata[31:8], dmem_wstrb[3:1]};

endmodule

// File: tb/tb_dmem_mmio_uart.sv
// Randomized and directed bench for dmem_mmio_uart against a queue-based frame-timing reference model.
module tb_dmem_mmio_uart;
   localparam int          C    = 4;
   localparam int          D    = 8;
   localparam logic [31:0] BASE = 32'h1000_0000;

   logic        clk, rst, dmem_we;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_wstrb;
   logic        uart_tx, tx_busy;

   int n_tests = 0;
   int n_fail  = 0;

   dmem_mmio_uart #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D), .BASE_ADDR(BASE)) dut (
      .clk(clk), .rst(rst), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
      .dmem_wstrb(dmem_wstrb), .dmem_we(dmem_we), .dmem_rdata(dmem_rdata),
      .uart_tx(uart_tx), .tx_busy(tx_busy));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference model: FIFO as a queue, transmitter as a cycle offset into a 10*C frame.
   logic [7:0] mq[$];
   logic       m_ovf = 1'b0;
   logic       m_act = 1'b0;
   int         m_t   = 0;
   logic [7:0] m_cur = 8'h0;

   function automatic logic [31:0] m_status();
      logic [6:0] cnt;
      cnt = 7'(mq.size());
      return {21'h0, cnt, m_ovf, m_act, mq.size() == 0, mq.size() == D};
   endfunction

   function automatic logic m_tx();
      if (!m_act)         return 1'b1;
      if (m_t < C)        return 1'b0;
      if (m_t < 9 * C)    return m_cur[(m_t - C) / C];
      return 1'b1;
   endfunction

   task automatic m_update(input logic r, input logic we, input logic [31:0] a,
                           input logic [31:0] wd, input logic [3:0] ws);
      logic sel, push, clr, pop, ovf_evt;
      if (r) begin
         mq.delete();
         m_ovf = 1'b0;
         m_act = 1'b0;
         m_t   = 0;
         return;
      end
      sel     = (a[31:3] == BASE[31:3]);
      push    = we && sel && !a[2] && ws[0];
      clr     = we && sel && a[2] && ws[0] && wd[3];
      pop     = (mq.size() > 0) && (!m_act || m_t == 10 * C - 1);
      ovf_evt = push && (mq.size() == D) && !pop;
      if (pop) m_cur = mq.pop_front();
      if (push && !ovf_evt) mq.push_back(wd[7:0]);
      if (ovf_evt) m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
      if (pop) begin
         m_act = 1'b1;
         m_t   = 0;
      end else if (m_act) begin
         if (m_t == 10 * C - 1) m_act = 1'b0;
         else m_t++;
      end
   endtask

   task automatic set_idle();
      rst = 1'b0; dmem_we = 1'b0; dmem_addr = 32'h0; dmem_wdata = 32'h0; dmem_wstrb = 4'h0;
   endtask

   // One clock: model tracks the edge, then outputs and register reads are compared.
   task automatic step();
      logic r, we;
      logic [31:0] a, wd;
      logic [3:0] ws;
      r = rst; we = dmem_we; a = dmem_addr; wd = dmem_wdata; ws = dmem_wstrb;
      @(posedge clk);
      m_update(r, we, a, wd, ws);
      #1;
      check("uart_tx", uart_tx, m_tx());
      check("tx_busy", tx_busy, m_act);
      set_idle();
      dmem_addr = BASE + 32'd4;
      #1 check("status", dmem_rdata, m_status());
      dmem_addr = BASE + 32'd1;
      #1 check("data_rd", dmem_rdata, 32'h0);
      dmem_addr = BASE + 32'd8;
      #1 check("oow_rd", dmem_rdata, 32'h0);
      dmem_addr = 32'h0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      dmem_we = 1'b1; dmem_addr = a; dmem_wdata = d; dmem_wstrb = s;
      step();
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && (m_act || mq.size() > 0); i++) step();
      step();
      check("drain_busy", tx_busy, 1'b0);
   endtask

   // Independent UART receiver sampling at mid-bit.
   logic [7:0] rx[$];
   logic       rx_en = 1'b0;
   initial begin
      logic [7:0] b;
      forever begin
         @(negedge clk);
         if (rx_en && uart_tx === 1'b0) begin
            repeat (C / 2) @(negedge clk);
            for (int k = 0; k < 8; k++) begin
               repeat (C) @(negedge clk);
               b[k] = uart_tx;
            end
            repeat (C) @(negedge clk);
            rx.push_back(b);
         end
      end
   end

   initial begin
      int first, n_busy, mism, sent;
      logic [9:0] frame;
      set_idle();
      rst = 1'b1;
      step();
      rst = 1'b1;
      step();
      #1;
      dmem_addr = BASE + 32'd4;
      #1 check("reset_status", dmem_rdata, 32'h2);
      check("reset_tx", uart_tx, 1'b1);

      // Single byte, exact waveform.
      frame = {1'b1, 8'hA5, 1'b0};
      wr(BASE, 32'hFFFF_FFA5, 4'h1);
      first = -1; n_busy = 0; mism = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (tx_busy) begin
            if (first < 0) first = i;
            if (uart_tx !== frame[(i - first) / C]) mism++;
            n_busy++;
         end
      end
      check("a5_latency", first, 0);
      check("a5_busy_len", n_busy, 10 * C);
      check("a5_wave_mism", mism, 0);
      dmem_addr = BASE + 32'd4;
      #1 check("a5_status_after", dmem_rdata, 32'h2);

      // Back-to-back frames with no idle gap.
      wr(BASE, 32'h55, 4'h1);
      wr(BASE, 32'h0F, 4'h1);
      n_busy = 0;
      for (int i = 0; i < 100; i++) begin
         step();
         if (i == 10) begin
            dmem_addr = BASE + 32'd4;
            #1 check("b2b_count", dmem_rdata[10:4], 7'd1);
            dmem_addr = 32'h0;
         end
         if (tx_busy) n_busy++;
      end
      check("b2b_busy_len", n_busy, 20 * C - 1);

      // Overflow and clear.
      for (int i = 0; i < 10; i++) wr(BASE, 32'h30 + i, 4'h1);
      dmem_addr = BASE + 32'd4;
      #1 check("ovf_status", dmem_rdata, 32'h8D);
      wr(BASE + 32'd4, 32'h8, 4'hF);
      dmem_addr = BASE + 32'd4;
      #1 check("ovf_cleared", dmem_rdata, 32'h85);
      drain(600);

      // Wrap-around streaming, decoded by the receiver.
      rx.delete();
      rx_en = 1'b1;
      sent = 0;
      for (int i = 0; i < 2000 && sent < 20; i++) begin
         if (mq.size() < D - 1 && ($urandom_range(0, 3) == 0)) begin
            wr(BASE, 32'(sent), 4'h1);
            sent++;
         end else begin
            step();
         end
      end
      drain(1000);
      repeat (2 * C) step();
      rx_en = 1'b0;
      check("wrap_rx_count", rx.size(), 20);
      for (int i = 0; i < 20; i++)
         check("wrap_rx_byte", (i < rx.size()) ? 32'(rx[i]) : 32'hFFFF_FFFF, 32'(i));

      // Reset during data bit 3.
      wr(BASE, 32'hFF, 4'h1);
      wr(BASE, 32'h11, 4'h1);
      repeat (C * 4 + 1) step();
      rst = 1'b1;
      step();
      check("midrst_tx", uart_tx, 1'b1);
      check("midrst_busy", tx_busy, 1'b0);
      dmem_addr = BASE + 32'd4;
      #1 check("midrst_status", dmem_rdata, 32'h2);
      n_busy = 0;
      for (int i = 0; i < 50; i++) begin
         step();
         if (tx_busy) n_busy++;
      end
      check("midrst_no_frame", n_busy, 0);

      // Decode negatives.
      wr(BASE + 32'd8, 32'h77, 4'hF);
      wr(BASE, 32'h7700, 4'b0010);
      dmem_we = 1'b0; dmem_addr = BASE; dmem_wdata = 32'h77; dmem_wstrb = 4'h1;
      step();
      dmem_addr = BASE + 32'd4;
      #1 check("decode_status", dmem_rdata, 32'h2);

      // Random traffic including resets that coincide with writes.
      for (int i = 0; i < 4000; i++) begin
         int r;
         r = $urandom_range(0, 19);
         dmem_wdata = $urandom();
         dmem_wstrb = 4'($urandom());
         dmem_we    = 1'b1;
         case (r)
            0, 1, 2:  begin dmem_addr = BASE + 32'($urandom_range(0, 3)); dmem_wstrb[0] = 1'b1; end
            3:        dmem_addr = BASE;
            4:        dmem_addr = BASE + 32'd4 + 32'($urandom_range(0, 3));
            5:        dmem_addr = BASE + 32'd8;
            6:        dmem_addr = $urandom();
            7:        begin dmem_addr = BASE; dmem_we = 1'b0; end
            default:  dmem_we = 1'b0;
         endcase
         rst = ($urandom_range(0, 299) == 0);
         step();
      end
      drain(1000);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
